battleship_shot_resolver: RTL and testbench
===========================================

// Module: battleship_shot_resolver
// PURPOSE
// Reader side of the 5x5 board arrays built by the ship-placement block. Runs the
// firing phase: alternates player and PC turns, reads the opponent board at the
// shot coordinate, records HIT/MISS in a per-side shot map (the VGA layer reads it),
// counts hits and declares game over and the winner. Enabled by the FSM's play state.
// PARAMETERS
// N         5    board dimension, rows/cols 0..N-1, N<=7
// PC_DELAY  50   clk cycles the PC waits before its shot is accepted (>=1)
// PORTS
// clk              in   1       system clock, rising edge
// rst              in   1       reset, asynchronous, active-low
// game_active      in   1       high while top FSM is in play state
// fire_button      in   1       player fire; falling edge 1->0 = one shot request
// i_aim, j_aim     in   3       player cursor row/col
// i_random,j_random in  3       PC random row/col, may change every cycle
// ship_cells_pc    in   5       total BARCO cells on PC board
// ship_cells_jug   in   5       total BARCO cells on player board
// tablero_pc       in   2x[N][N] PC board, 2'b01 = BARCO, else water
// tablero_jugador  in   2x[N][N] player board, same coding
// shots_jug        out  2x[N][N] player's shots on PC board: 00 none,01 miss,10 hit
// shots_pc         out  2x[N][N] PC's shots on player board, same coding
// player_hits      out  5       hits scored by player
// pc_hits          out  5       hits scored by PC
// player_turn      out  1       1 while waiting for player shot
// last_result      out  2       result of most recent shot, 00/01/10 as above
// game_over        out  1       sticky; set when either side reaches its target
// winner           out  1       valid when game_over: 0 player, 1 PC
// BEHAVIOUR
// - rst low: all outputs 0, all map cells 00, state IDLE, fire_prev 1, delay cnt 0.
// - fire edge: registered fire_prev; edge = fire_prev & !fire_button, one per press.
// - States: IDLE, P_AIM, P_RES, PC_WAIT, PC_FIRE, PC_RES, OVER.
// - IDLE: game_active -> P_AIM. player_turn=1 only in P_AIM.
// - P_AIM: on edge with i_aim<N, j_aim<N and shots_jug[i][j]==00: latch coords,
//   -> P_RES. Out-of-range or already-shot cell: edge ignored, stay P_AIM.
// - P_RES (1 cycle): mark 10 if tablero_pc[i][j]==01 else 01; last_result same;
//   on hit player_hits+1. If new hit count == ship_cells_pc -> OVER, winner=0,
//   else -> PC_WAIT with delay cnt cleared. Mark visible edge after P_RES entry.
// - PC_WAIT: count PC_DELAY cycles, then -> PC_FIRE.
// - PC_FIRE: each cycle test i/j_random: in range and shots_pc cell 00 -> latch,
//   -> PC_RES; else stay and retry next cycle (no bound; random source changes).
// - PC_RES: mirror of P_RES on tablero_jugador/shots_pc/pc_hits vs ship_cells_jug;
//   win -> OVER, winner=1; else -> P_AIM.
// - OVER: game_over=1, holds all maps/counters; ignores fire; leave only by rst.
// - game_active low in any non-OVER state: -> IDLE next cycle, maps/counters kept.
// - Board inputs sampled only in *_RES; counters 5-bit, never exceed 25.
// - Target count 0: no win check fires; fire still recorded (miss on water).
// - Fire edge during non-P_AIM states discarded, not queued.
// - rst mid-game: immediate clear regardless of state.
// TESTING
// 1 Reset, game_active=1 -> maps all 00, hits 0, game_over 0, player_turn 1 after 1 clk.
// 2 PC BARCO at (1,2), fire at (1,2) -> shots_jug[1][2]=10, player_hits=1,
//   last_result=10, player_turn 0 for PC_DELAY+ cycles.
// 3 Fire at water (0,0) -> 01; next turn fire (0,0) again -> ignored, stays P_AIM;
//   i_aim=5 -> ignored.
// 4 PC_FIRE with random = already-shot cell 3 cycles then fresh (4,4) -> only
//   shots_pc[4][4] written, exactly one pc shot, back to P_AIM.
// 5 ship_cells_pc=1, hit it -> game_over=1, winner=0; further fire edges no effect;
//   ship_cells_jug=1 with PC hit -> winner=1.
// 6 rst pulse during PC_WAIT -> all outputs and maps 0 asynchronously; holding
//   fire_button low through reset release produces no shot.

Source files
------------

// File: rtl/battleship_shot_resolver.sv
// battleship_shot_resolver: firing phase of the 5x5 game, alternating player and PC shots,
// recording hit/miss maps, counting hits and declaring the winner.
module battleship_shot_resolver #(
   parameter int N        = 5,
   parameter int PC_DELAY = 50
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       game_active,
   input  logic                       fire_button,
   input  logic [2:0]                 i_aim,
   input  logic [2:0]                 j_aim,
   input  logic [2:0]                 i_random,
   input  logic [2:0]                 j_random,
   input  logic [4:0]                 ship_cells_pc,
   input  logic [4:0]                 ship_cells_jug,
   input  logic [N-1:0][N-1:0][1:0]   tablero_pc,
   input  logic [N-1:0][N-1:0][1:0]   tablero_jugador,
   output logic [N-1:0][N-1:0][1:0]   shots_jug,
   output logic [N-1:0][N-1:0][1:0]   shots_pc,
   output logic [4:0]                 player_hits,
   output logic [4:0]                 pc_hits,
   output logic                       player_turn,
   output logic [1:0]                 last_result,
   output logic                       game_over,
   output logic                       winner
);
   localparam int CW = $clog2(PC_DELAY + 1);
   typedef enum logic [2:0] {IDLE, P_AIM, P_RES, PC_WAIT, PC_FIRE, PC_RES, OVER} state_t;
   state_t                     state_q, state_d;
   logic                       fire_prev_q;
   logic [2:0]                 ri_q, ri_d, rj_q, rj_d;
   logic [CW-1:0]              cnt_q, cnt_d;
   logic [N-1:0][N-1:0][1:0]   shots_jug_q, shots_jug_d, shots_pc_q, shots_pc_d;
   logic [4:0]                 player_hits_q, player_hits_d, pc_hits_q, pc_hits_d;
   logic [1:0]                 last_q, last_d;
   logic                       over_q, over_d, winner_q, winner_d;
   logic                       fire_edge, aim_ok, rand_ok, p_hit, c_hit;
   assign fire_edge = fire_prev_q & ~fire_button;
   assign aim_ok    = i_aim < 3'(N) && j_aim < 3'(N) && shots_jug_q[i_aim][j_aim] == 2'b00;
   assign rand_ok   = i_random < 3'(N) && j_random < 3'(N) && shots_pc_q[i_random][j_random] == 2'b00;
   // one latched coordinate pair serves whichever side is resolving
   assign p_hit     = tablero_pc[ri_q][rj_q] == 2'b01;
   assign c_hit     = tablero_jugador[ri_q][rj_q] == 2'b01;
   always_comb begin
      state_d       = state_q;
      ri_d          = ri_q;
      rj_d          = rj_q;
      cnt_d         = cnt_q;
      shots_jug_d   = shots_jug_q;
      shots_pc_d    = shots_pc_q;
      player_hits_d = player_hits_q;
      pc_hits_d     = pc_hits_q;
      last_d        = last_q;
      over_d        = over_q;
      winner_d      = winner_q;
      if (!game_active && state_q != OVER) state_d = IDLE;
      else case (state_q)
         IDLE:    state_d = P_AIM;
         P_AIM: if (fire_edge && aim_ok) begin
            ri_d    = i_aim;
            rj_d    = j_aim;
            state_d = P_RES;
         end
         P_RES: begin
            shots_jug_d[ri_q][rj_q] = p_hit ? 2'b10 : 2'b01;
            last_d                  = p_hit ? 2'b10 : 2'b01;
            player_hits_d           = player_hits_q + {4'd0, p_hit};
            if (ship_cells_pc != 5'd0 && player_hits_d == ship_cells_pc) begin
               state_d  = OVER;
               over_d   = 1'b1;
               winner_d = 1'b0;
            end else begin
               state_d = PC_WAIT;
               cnt_d   = '0;
            end
         end
         PC_WAIT: begin
            cnt_d   = cnt_q + 1'b1;
            state_d = cnt_q == CW'(PC_DELAY - 1) ? PC_FIRE : PC_WAIT;
         end
         PC_FIRE: if (rand_ok) begin
            ri_d    = i_random;
            rj_d    = j_random;
            state_d = PC_RES;
         end
         PC_RES: begin
            shots_pc_d[ri_q][rj_q] = c_hit ? 2'b10 : 2'b01;
            last_d                 = c_hit ? 2'b10 : 2'b01;
            pc_hits_d              = pc_hits_q + {4'd0, c_hit};
            if (ship_cells_jug != 5'd0 && pc_hits_d == ship_cells_jug) begin
               state_d  = OVER;
               over_d   = 1'b1;
               winner_d = 1'b1;
            end else state_d = P_AIM;
         end
         default: state_d = OVER;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         fire_prev_q   <= 1'b1;
         ri_q          <= '0;
         rj_q          <= '0;
         cnt_q         <= '0;
         shots_jug_q   <= '0;
         shots_pc_q    <= '0;
         player_hits_q <= '0;
         pc_hits_q     <= '0;
         last_q        <= '0;
         over_q        <= 1'b0;
         winner_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         fire_prev_q   <= fire_button;
         ri_q          <= ri_d;
         rj_q          <= rj_d;
         cnt_q         <= cnt_d;
         shots_jug_q   <= shots_jug_d;
         shots_pc_q    <= shots_pc_d;
         player_hits_q <= player_hits_d;
         pc_hits_q     <= pc_hits_d;
         last_q        <= last_d;
         over_q        <= over_d;
         winner_q      <= winner_d;
      end
   end
   assign shots_jug   = shots_jug_q;
   assign shots_pc    = shots_pc_q;
   assign player_hits = player_hits_q;
   assign pc_hits     = pc_hits_q;
   assign player_turn = state_q == P_AIM;
   assign last_result = last_q;
   assign game_over   = over_q;
   assign winner      = winner_q;
endmodule

// File: tb/tb_battleship_shot_resolver.sv
// tb_battleship_shot_resolver: directed game scenarios with hand-computed maps and counters.
module tb_battleship_shot_resolver;
   localparam int N  = 5;
   localparam int PD = 4;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic                     rst, game_active, fire_button, player_turn, game_over, winner;
   logic [2:0]               i_aim, j_aim, i_random, j_random;
   logic [4:0]               ship_cells_pc, ship_cells_jug, player_hits, pc_hits;
   logic [1:0]               last_result;
   logic [N-1:0][N-1:0][1:0] tablero_pc, tablero_jugador, shots_jug, shots_pc, ej, ep;
   int                       n_chk = 0, n_fail = 0, n;
   battleship_shot_resolver #(.N(N), .PC_DELAY(PD)) dut (
      .clk(clk), .rst(rst), .game_active(game_active), .fire_button(fire_button),
      .i_aim(i_aim), .j_aim(j_aim), .i_random(i_random), .j_random(j_random),
      .ship_cells_pc(ship_cells_pc), .ship_cells_jug(ship_cells_jug),
      .tablero_pc(tablero_pc), .tablero_jugador(tablero_jugador),
      .shots_jug(shots_jug), .shots_pc(shots_pc), .player_hits(player_hits), .pc_hits(pc_hits),
      .player_turn(player_turn), .last_result(last_result), .game_over(game_over), .winner(winner)
   );
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic step(input int k = 1);
      repeat (k) @(negedge clk);
   endtask
   task automatic press(input logic [2:0] i, input logic [2:0] j);
      i_aim = i;
      j_aim = j;
      fire_button = 1'b0;
      step();
      fire_button = 1'b1;
   endtask
   task automatic wait_turn(output int cnt);
      cnt = 0;
      while (!player_turn && cnt < 200) begin
         step();
         cnt++;
      end
   endtask
   initial begin
      rst = 1'b0; game_active = 1'b1; fire_button = 1'b1;
      i_aim = 0; j_aim = 0; i_random = 0; j_random = 0;
      ship_cells_pc = 5'd5; ship_cells_jug = 5'd5;
      tablero_pc = '0; tablero_jugador = '0; ej = '0; ep = '0;
      tablero_pc[1][2] = 2'b01; tablero_pc[3][3] = 2'b01; tablero_pc[0][4] = 2'b01;
      tablero_pc[0][0] = 2'b11;
      tablero_jugador[2][2] = 2'b01; tablero_jugador[4][4] = 2'b01; tablero_jugador[0][0] = 2'b10;
      step(2);
      check("rst_shots_jug", 64'(shots_jug), 64'(ej));
      check("rst_shots_pc", 64'(shots_pc), 64'(ep));
      check("rst_hits", {player_hits, pc_hits}, 10'd0);
      check("rst_flags", {player_turn, game_over, winner, last_result}, 5'd0);
      rst = 1'b1;
      step();
      check("turn_after_rst", player_turn, 1'b1);
      // player hit at (1,2), PC misses at (0,0)
      press(3'd1, 3'd2);
      check("turn_off", player_turn, 1'b0);
      step();
      ej[1][2] = 2'b10;
      check("hit_map", 64'(shots_jug), 64'(ej));
      check("hit_count", player_hits, 5'd1);
      check("hit_last", last_result, 2'b10);
      wait_turn(n);
      check("pc_delay", n, PD + 2);
      ep[0][0] = 2'b01;
      check("pc_miss_map", 64'(shots_pc), 64'(ep));
      check("pc_miss_last", {pc_hits, last_result}, {5'd0, 2'b01});
      // player misses on non-01 water, PC hits (2,2)
      i_random = 3'd2; j_random = 3'd2;
      press(3'd0, 3'd0);
      step();
      ej[0][0] = 2'b01;
      check("miss_map", 64'(shots_jug), 64'(ej));
      check("miss_last", {player_hits, last_result}, {5'd1, 2'b01});
      wait_turn(n);
      ep[2][2] = 2'b10;
      check("pc_hit_map", 64'(shots_pc), 64'(ep));
      check("pc_hit_count", {pc_hits, last_result}, {5'd1, 2'b10});
      // repeated and out-of-range shots are ignored
      press(3'd0, 3'd0);
      step(2);
      check("dup_ignored", player_turn, 1'b1);
      press(3'd5, 3'd0);
      step(2);
      check("i5_ignored", player_turn, 1'b1);
      press(3'd2, 3'd6);
      step(2);
      check("j6_ignored", player_turn, 1'b1);
      check("ignored_map", 64'(shots_jug), 64'(ej));
      // PC retries on already-shot/out-of-range randoms before a fresh cell
      i_random = 3'd0; j_random = 3'd0;
      press(3'd3, 3'd3);
      step();
      ej[3][3] = 2'b10;
      check("hit2_count", player_hits, 5'd2);
      step(PD);
      step();
      i_random = 3'd2; j_random = 3'd2;
      step();
      i_random = 3'd6; j_random = 3'd1;
      step();
      check("retry_wait", player_turn, 1'b0);
      check("retry_map", 64'(shots_pc), 64'(ep));
      i_random = 3'd4; j_random = 3'd4;
      step(2);
      check("retry_back", player_turn, 1'b1);
      ep[4][4] = 2'b10;
      check("retry_fresh_map", 64'(shots_pc), 64'(ep));
      check("retry_pc_hits", pc_hits, 5'd2);
      // player reaches target
      ship_cells_pc = 5'd3;
      press(3'd0, 3'd4);
      step();
      ej[0][4] = 2'b10;
      check("win_p_flags", {game_over, winner, player_turn}, 3'b100);
      check("win_p_hits", player_hits, 5'd3);
      check("win_p_map", 64'(shots_jug), 64'(ej));
      press(3'd1, 3'd1);
      step(PD + 5);
      check("over_map_jug", 64'(shots_jug), 64'(ej));
      check("over_map_pc", 64'(shots_pc), 64'(ep));
      check("over_hold", {game_over, winner, player_hits, pc_hits}, {2'b10, 5'd3, 5'd2});
      // async reset during PC_WAIT, fire held low through release
      rst = 1'b0;
      step();
      rst = 1'b1;
      ship_cells_pc = 5'd5;
      step();
      check("regame_turn", player_turn, 1'b1);
      press(3'd1, 3'd2);
      step(2);
      #2 rst = 1'b0;
      #1;
      check("arst_maps", {64'(shots_jug), 64'(shots_pc)}, 128'd0);
      check("arst_outs", {player_hits, pc_hits, last_result, player_turn, game_over, winner}, 15'd0);
      fire_button = 1'b0;
      i_aim = 3'd3; j_aim = 3'd3;
      @(negedge clk);
      rst = 1'b1;
      step(3);
      check("rel_no_shot", {player_turn, 64'(shots_jug)}, {1'b1, 64'd0});
      fire_button = 1'b1;
      step();
      // PC reaches target
      ej = '0; ep = '0;
      ship_cells_jug = 5'd1;
      i_random = 3'd2; j_random = 3'd2;
      press(3'd4, 3'd0);
      step();
      check("pcwin_pmiss", {player_hits, last_result}, {5'd0, 2'b01});
      n = 0;
      while (!game_over && n < 100) begin
         step();
         n++;
      end
      ep[2][2] = 2'b10;
      check("win_pc_flags", {game_over, winner, player_turn}, 3'b110);
      check("win_pc_hits", pc_hits, 5'd1);
      check("win_pc_map", 64'(shots_pc), 64'(ep));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
